// File: rtl/top_psram_bringup.sv
// top_psram_bringup: board top for PSRAM bring-up.
// Contains the PLL-lock model, the burst-RAM init/calibration sequencer,
// the internal N x DATA_WIDTH burst RAM and the active-low status LEDs.
// Optional feature: define BR_SELFTEST_EN to build the endless post-calibration
// burst self-test (drives led[5:3]); undefined leaves led[5:3] = 3'b111.
module top_psram_bringup #(
  parameter int unsigned     BURST_RAM_DEPTH_BITWIDTH = 4,
  parameter int unsigned     DATA_WIDTH               = 8,
  parameter int unsigned     LOCK_CYCLES              = 16,
  parameter int unsigned     INIT_WAIT_CYCLES         = 64,
  parameter logic [7:0]      CALIB_PATTERN            = 8'hA5,
  parameter int unsigned     MAX_RETRY                = 7
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  output logic       rpll_lock,
  output logic       br_init_calib,
  output logic       cal_fail,
  output logic [5:0] led
);

  localparam int unsigned AW      = BURST_RAM_DEPTH_BITWIDTH;
  localparam int unsigned DW      = DATA_WIDTH;
  localparam int unsigned N       = 1 << AW;
  localparam int unsigned CNT_MAX = (INIT_WAIT_CYCLES > 2 * N + 1) ? INIT_WAIT_CYCLES : 2 * N + 1;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned LK_W    = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned RT_W    = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] CNT_WAIT_END = CNT_W'(INIT_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_WR_END   = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_N        = CNT_W'(N);
  localparam logic [LK_W-1:0]  LOCK_END     = LK_W'(LOCK_CYCLES - 1);
  localparam logic [RT_W-1:0]  RETRY_MAX    = RT_W'(MAX_RETRY);
`ifdef BR_SELFTEST_EN
  localparam logic [CNT_W-1:0] CNT_2N       = CNT_W'(2 * N);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CAL_WR,
    S_CAL_RD,
    S_DONE,
    S_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LK_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic             err_q, err_d;
  logic             rpll_lock_q, rpll_lock_d;
  logic             calib_q, calib_d;
  logic             fail_q, fail_d;
  logic [5:0]       led_q, led_d;
`ifdef BR_SELFTEST_EN
  logic [7:0]       pass_q, pass_d;
  logic             st_err_q, st_err_d;
`endif

  // Burst RAM signals
  logic [DW-1:0]    mem_q [N];
  logic [DW-1:0]    rd_data_q;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    cmp_addr;
  logic [DW-1:0]    seed;
  logic [DW-1:0]    wr_data;
  logic [DW-1:0]    exp_data;
  logic             mismatch;
  logic             err_now;
  logic [2:0]       led_hi;

  // Burst RAM: synchronous write, registered read; same-address read returns old data
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  // Lock model and sequencer next-state logic
  always_comb begin
    lock_cnt_d  = lock_cnt_q;
    rpll_lock_d = rpll_lock_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    err_d       = err_q;
    calib_d     = calib_q;
    fail_d      = fail_q;
`ifdef BR_SELFTEST_EN
    pass_d      = pass_q;
    st_err_d    = st_err_q;
    seed        = (state_q == S_DONE) ? DW'(pass_q) : DW'(CALIB_PATTERN);
`else
    seed        = DW'(CALIB_PATTERN);
`endif
    we          = 1'b0;
    // Reads issue at cnt and compare one cycle later against address cnt-1;
    // the low address bits wrap so the same formulas serve both read phases.
    wr_addr     = cnt_q[AW-1:0];
    rd_addr     = cnt_q[AW-1:0];
    cmp_addr    = cnt_q[AW-1:0] - 1'b1;
    wr_data     = DW'(wr_addr) ^ seed;
    exp_data    = DW'(cmp_addr) ^ seed;
    mismatch    = (rd_data_q != exp_data);
    err_now     = err_q | ((cnt_q != '0) && mismatch);

    if (!rpll_lock_q) begin
      lock_cnt_d  = lock_cnt_q + 1'b1;
      rpll_lock_d = (lock_cnt_q == LOCK_END);
    end

    case (state_q)
      S_IDLE: begin
        if (rpll_lock_q) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_WAIT_END) begin
          state_d = S_CAL_WR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAL_WR: begin
        we = 1'b1;
        if (cnt_q == CNT_WR_END) begin
          state_d = S_CAL_RD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAL_RD: begin
        if (cnt_q == CNT_N) begin
          cnt_d = '0;
          if (!err_now) begin
            state_d = S_DONE;
            calib_d = 1'b1;
          end else if (retry_q < RETRY_MAX) begin
            state_d = S_CAL_WR;
            retry_d = retry_q + 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
            calib_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          err_d = err_now;
        end
      end
      S_DONE: begin
`ifdef BR_SELFTEST_EN
        if (!st_err_q) begin
          if (cnt_q < CNT_N) begin
            we    = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end else if ((cnt_q > CNT_N) && mismatch) begin
            st_err_d = 1'b1;
          end else if (cnt_q == CNT_2N) begin
            pass_d = pass_q + 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      default: ;
    endcase

`ifdef BR_SELFTEST_EN
    led_hi = st_err_d ? 3'b000 : ~pass_d[2:0];
`else
    led_hi = 3'b111;
`endif
    led_d = {led_hi, ~fail_d, ~calib_d, ~rpll_lock_d};
  end

  // State and registered outputs; reset aborts and restarts the whole sequence
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lock_cnt_q  <= '0;
      retry_q     <= '0;
      err_q       <= 1'b0;
      rpll_lock_q <= 1'b0;
      calib_q     <= 1'b0;
      fail_q      <= 1'b0;
      led_q       <= '1;
`ifdef BR_SELFTEST_EN
      pass_q      <= '0;
      st_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      retry_q     <= retry_d;
      err_q       <= err_d;
      rpll_lock_q <= rpll_lock_d;
      calib_q     <= calib_d;
      fail_q      <= fail_d;
      led_q       <= led_d;
`ifdef BR_SELFTEST_EN
      pass_q      <= pass_d;
      st_err_q    <= st_err_d;
`endif
    end
  end

  assign rpll_lock     = rpll_lock_q;
  assign br_init_calib = calib_q;
  assign cal_fail      = fail_q;
  assign led           = led_q;

endmodule

// File: tb/tb_top_psram_bringup.sv
// Directed bench for top_psram_bringup. Expectations are queued with the
// cycle (rising edges since reset release) at which they must hold and are
// popped and compared on the falling edge of that cycle.
module tb_top_psram_bringup;

  logic       sys_clk;
  logic       sys_rst;
  logic       rpll_lock;
  logic       br_init_calib;
  logic       cal_fail;
  logic [5:0] led;

  top_psram_bringup dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .rpll_lock     (rpll_lock),
    .br_init_calib (br_init_calib),
    .cal_fail      (cal_fail),
    .led           (led)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned cyc;
    string       tag;
    logic [8:0]  exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks;
  int          failures;

  function automatic logic [8:0] mk(input logic lock, input logic calib,
                                    input logic fail, input logic [2:0] hi);
    return {lock, calib, fail, hi, ~fail, ~calib, ~lock};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = {rpll_lock, br_init_calib, cal_fail, led};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int unsigned c, input string tag, input logic [8:0] exp);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
`ifndef BR_SELFTEST_EN
    checks++;
    assert (led[5:3] === 3'b111) else begin
      failures++;
      $error("FAIL led_hi cyc=%0d observed=%b expected=111", cyc, led[5:3]);
    end
`endif
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      check(e.tag, e.exp);
    end
  endtask

  task automatic run_to(input int unsigned target);
    while (cyc < target) step();
  endtask

  task automatic apply_reset(input int unsigned n);
    sys_rst = 1'b1;
    repeat (n) @(negedge sys_clk);
    check("reset_hold", mk(1'b0, 1'b0, 1'b0, 3'b111));
    sys_rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    sys_rst  = 1'b1;

    // 1: long reset
    apply_reset(27);

    // 2: nominal bring-up
    push(15,  "lock_pre",   mk(1'b0, 1'b0, 1'b0, 3'b111));
    push(16,  "lock_rise",  mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(90,  "mid_cal",    mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(113, "calib_pre",  mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(114, "calib_rise", mk(1'b1, 1'b1, 1'b0, 3'b111));
    run_to(114);

    // 3: reset mid CAL_WR, asynchronous drop, then full restart
    apply_reset(2);
    run_to(90);
    sys_rst = 1'b1;
    #1;
    check("async_drop", mk(1'b0, 1'b0, 1'b0, 3'b111));
    apply_reset(3);
    push(16,  "re_lock",       mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(113, "re_calib_pre",  mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(114, "re_calib_rise", mk(1'b1, 1'b1, 1'b0, 3'b111));
    run_to(114);

    // 4: read data stuck at zero -> initial pass plus MAX_RETRY retries, then FAIL
    sys_rst = 1'b1;
    @(negedge sys_clk);
    force dut.rd_data_q = '0;
    apply_reset(2);
    push(114, "bad_no_calib", mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(312, "bad_retrying", mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(344, "fail_pre",     mk(1'b1, 1'b0, 1'b0, 3'b111));
    push(345, "fail_rise",    mk(1'b1, 1'b0, 1'b1, 3'b111));
    push(400, "fail_hold",    mk(1'b1, 1'b0, 1'b1, 3'b111));
    run_to(400);
    release dut.rd_data_q;

    // 5/6: clean run after fail; self-test counting when built in
    apply_reset(2);
    push(114, "calib_again", mk(1'b1, 1'b1, 1'b0, 3'b111));
`ifdef BR_SELFTEST_EN
    push(146, "st_pass0", mk(1'b1, 1'b1, 1'b0, 3'b111));
    push(147, "st_pass1", mk(1'b1, 1'b1, 1'b0, 3'b110));
    push(180, "st_pass2", mk(1'b1, 1'b1, 1'b0, 3'b101));
    push(213, "st_pass3", mk(1'b1, 1'b1, 1'b0, 3'b100));
    run_to(213);
`else
    push(250, "calib_hold", mk(1'b1, 1'b1, 1'b0, 3'b111));
    run_to(250);
`endif

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
